// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite animation sequencer.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    HOLD
  } anim_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = $clog2((SCREEN_W > SCREEN_H) ? SCREEN_W : SCREEN_H);

  localparam int SPR_W_DEF    = 64;
  localparam int SPR_H_DEF    = 64;
  localparam int N_FRAMES_DEF = 8;

endpackage

// File: rtl/sprite_addr_gen.sv
// Sprite box test and ROM address generation, with an in-box flag delayed
// so it lines up with the ROM read data for the same pixel.
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int SPR_W    = SPR_W_DEF,
  parameter int SPR_H    = SPR_H_DEF,
  parameter int N_FRAMES = N_FRAMES_DEF,
  parameter int ADDR_W   = 15,
  parameter int ROM_LAT  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(N_FRAMES)-1:0]   frame_idx,
  input  logic [COORD_W-1:0]            pos_x,
  input  logic [COORD_W-1:0]            pos_y,
  input  logic [COORD_W-1:0]            draw_x,
  input  logic [COORD_W-1:0]            draw_y,
  output logic [ADDR_W-1:0]             rom_address,
  output logic                          sprite_active
);

  localparam int LOG_W = $clog2(SPR_W);
  localparam int LOG_H = $clog2(SPR_H);

  logic [COORD_W:0]  rel_x_p0;
  logic [COORD_W:0]  rel_y_p0;
  logic              in_box_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [ROM_LAT:0]  act_p1;

  // Stage p0: box test and address; power-of-2 dimensions make the base a concat.
  always_comb begin
    rel_x_p0  = {1'b0, draw_x} - {1'b0, pos_x};
    rel_y_p0  = {1'b0, draw_y} - {1'b0, pos_y};
    in_box_p0 = (draw_x >= pos_x) && (rel_x_p0 < (COORD_W+1)'(SPR_W)) &&
                (draw_y >= pos_y) && (rel_y_p0 < (COORD_W+1)'(SPR_H));
    addr_p0   = '0;
    if (in_box_p0)
      addr_p0 = ADDR_W'({frame_idx, rel_y_p0[LOG_H-1:0], rel_x_p0[LOG_W-1:0]});
  end

  // Stage p1: registered address; in-box flag runs ROM_LAT further stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_address <= '0;
      act_p1      <= '0;
    end else begin
      rom_address <= addr_p0;
      act_p1[0]   <= in_box_p0;
      for (int i = 1; i <= ROM_LAT; i++)
        act_p1[i] <= act_p1[i-1];
    end
  end

  assign sprite_active = act_p1[ROM_LAT];

endmodule

// File: rtl/sprite_anim_sequencer.sv
// Frame-rate animation sequencer for a multi-frame sprite ROM; frame index and
// sprite position only change on frame_start so a displayed frame never tears.
module sprite_anim_sequencer
  import sprite_pkg::*;
#(
  parameter int SPR_W           = SPR_W_DEF,
  parameter int SPR_H           = SPR_H_DEF,
  parameter int N_FRAMES        = N_FRAMES_DEF,
  parameter int TICKS_PER_FRAME = 6,
  parameter int ADDR_W          = 15,
  parameter int ROM_LAT         = 1
) (
  input  logic                        vga_clk,
  input  logic                        Reset,
  input  logic                        frame_start,
  input  logic                        play,
  input  logic                        loop_en,
  input  logic [9:0]                  pos_x,
  input  logic [9:0]                  pos_y,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  output logic [ADDR_W-1:0]           rom_address,
  output logic                        sprite_active,
  output logic [$clog2(N_FRAMES)-1:0] frame_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int FIDX_W = $clog2(N_FRAMES);
  localparam int TICK_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam logic [FIDX_W-1:0] LAST_F   = FIDX_W'(N_FRAMES - 1);
  localparam logic [FIDX_W-1:0] PENULT_F = FIDX_W'(N_FRAMES - 2);
  localparam logic [FIDX_W-1:0] ONE_F    = FIDX_W'(1);
  localparam logic [TICK_W-1:0] LAST_T   = TICK_W'(TICKS_PER_FRAME - 1);
  localparam logic [TICK_W-1:0] ONE_T    = TICK_W'(1);

  anim_state_t       state;
  logic [TICK_W-1:0] tick_cnt;
  logic [9:0]        pos_sh_x;
  logic [9:0]        pos_sh_y;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      frame_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (play) begin
        // A restart swallows any coincident frame_start tick.
        state     <= PLAY;
        frame_idx <= '0;
        tick_cnt  <= '0;
        busy      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            frame_idx <= '0;
            busy      <= 1'b0;
          end
          PLAY: begin
            if (frame_start) begin
              if (tick_cnt == LAST_T) begin
                tick_cnt <= '0;
                if (frame_idx == LAST_F) begin
                  if (loop_en) begin
                    frame_idx <= '0;
                  end else begin
                    state <= HOLD;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                  end
                end else if (frame_idx == PENULT_F && !loop_en) begin
                  frame_idx <= LAST_F;
                  state     <= HOLD;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                end else begin
                  frame_idx <= frame_idx + ONE_F;
                end
              end else begin
                tick_cnt <= tick_cnt + ONE_T;
              end
            end
          end
          HOLD: begin
            frame_idx <= LAST_F;
            busy      <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      pos_sh_x <= '0;
      pos_sh_y <= '0;
    end else if (frame_start) begin
      pos_sh_x <= pos_x;
      pos_sh_y <= pos_y;
    end
  end

  sprite_addr_gen #(
    .SPR_W    (SPR_W),
    .SPR_H    (SPR_H),
    .N_FRAMES (N_FRAMES),
    .ADDR_W   (ADDR_W),
    .ROM_LAT  (ROM_LAT)
  ) u_addr_gen (
    .clk           (vga_clk),
    .rst           (Reset),
    .frame_idx     (frame_idx),
    .pos_x         (pos_sh_x),
    .pos_y         (pos_sh_y),
    .draw_x        (DrawX),
    .draw_y        (DrawY),
    .rom_address   (rom_address),
    .sprite_active (sprite_active)
  );

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Directed bench for sprite_anim_sequencer: address table plus sequencing scenarios.
module tb_sprite_anim_sequencer;

  logic        clk = 1'b0;
  logic        Reset, frame_start, play, loop_en;
  logic [9:0]  pos_x, pos_y, DrawX, DrawY;
  logic [14:0] rom_address;
  logic        sprite_active;
  logic [2:0]  frame_idx;
  logic        busy, done;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  sprite_anim_sequencer dut (
    .vga_clk       (clk),
    .Reset         (Reset),
    .frame_start   (frame_start),
    .play          (play),
    .loop_en       (loop_en),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .rom_address   (rom_address),
    .sprite_active (sprite_active),
    .frame_idx     (frame_idx),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  typedef struct {
    logic [9:0]  px, py, dx, dy;
    logic [14:0] addr;
    logic        act;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fs_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic play_pulse();
    play = 1'b1;
    @(negedge clk);
    play = 1'b0;
  endtask

  task automatic draw(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
  endtask

  int base;

  initial begin
    vecs[0] = '{10'd100, 10'd50,  10'd110, 10'd60,  15'd650,  1'b1};
    vecs[1] = '{10'd100, 10'd50,  10'd164, 10'd60,  15'd0,    1'b0};
    vecs[2] = '{10'd100, 10'd50,  10'd163, 10'd113, 15'd4095, 1'b1};
    vecs[3] = '{10'd100, 10'd50,  10'd99,  10'd60,  15'd0,    1'b0};
    vecs[4] = '{10'd100, 10'd50,  10'd100, 10'd114, 15'd0,    1'b0};
    vecs[5] = '{10'd600, 10'd450, 10'd639, 10'd479, 15'd1895, 1'b1};
    vecs[6] = '{10'd600, 10'd450, 10'd0,   10'd0,   15'd0,    1'b0};
    vecs[7] = '{10'd600, 10'd450, 10'd0,   10'd479, 15'd0,    1'b0};
    vecs[8] = '{10'd0,   10'd0,   10'd0,   10'd0,   15'd0,    1'b1};
    vecs[9] = '{10'd0,   10'd0,   10'd5,   10'd3,   15'd197,  1'b1};

    Reset = 1'b1; frame_start = 1'b0; play = 1'b0; loop_en = 1'b0;
    pos_x = '0; pos_y = '0; DrawX = 10'd1023; DrawY = 10'd1023;
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b0;
    chk("reset_frame_idx", 32'(frame_idx), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_rom_address", 32'(rom_address), 0);
    chk("reset_sprite_active", 32'(sprite_active), 0);

    // Address table at frame 0 in IDLE; parked draw point is outside every box.
    for (int i = 0; i < 10; i++) begin
      pos_x = vecs[i].px; pos_y = vecs[i].py;
      draw(1023, 1023);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      DrawX = vecs[i].dx; DrawY = vecs[i].dy;
      @(negedge clk);
      chk($sformatf("vec%0d_addr", i), 32'(rom_address), 32'(vecs[i].addr));
      chk($sformatf("vec%0d_act_early", i), 32'(sprite_active), 0);
      @(negedge clk);
      chk($sformatf("vec%0d_act", i), 32'(sprite_active), 32'(vecs[i].act));
      draw(1023, 1023);
    end

    // One-shot: hold on last frame.
    base = done_cnt;
    loop_en = 1'b0;
    play_pulse();
    chk("play_busy", 32'(busy), 1);
    chk("play_frame0", 32'(frame_idx), 0);
    fs_pulses(6);
    chk("oneshot_6_frame", 32'(frame_idx), 1);
    fs_pulses(35);
    chk("oneshot_41_frame", 32'(frame_idx), 6);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("oneshot_done_pulse", 32'(done), 1);
    chk("oneshot_42_frame", 32'(frame_idx), 7);
    chk("oneshot_42_busy", 32'(busy), 0);
    @(negedge clk);
    chk("oneshot_done_drop", 32'(done), 0);
    fs_pulses(10);
    chk("hold_frame", 32'(frame_idx), 7);
    chk("hold_busy", 32'(busy), 0);
    chk("oneshot_done_count", 32'(done_cnt - base), 1);

    // Looping: wraps to frame 0 without done.
    base = done_cnt;
    loop_en = 1'b1;
    play_pulse();
    chk("loop_restart_frame", 32'(frame_idx), 0);
    fs_pulses(42);
    chk("loop_42_frame", 32'(frame_idx), 7);
    chk("loop_42_busy", 32'(busy), 1);
    fs_pulses(6);
    chk("loop_48_frame", 32'(frame_idx), 0);
    chk("loop_48_busy", 32'(busy), 1);
    chk("loop_done_count", 32'(done_cnt - base), 0);

    // play together with frame_start at frame 5: restart and tick not counted.
    fs_pulses(30);
    chk("pre_collide_frame", 32'(frame_idx), 5);
    play = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    play = 1'b0; frame_start = 1'b0;
    chk("collide_frame", 32'(frame_idx), 0);
    chk("collide_busy", 32'(busy), 1);
    @(negedge clk);
    fs_pulses(5);
    chk("collide_tick_5", 32'(frame_idx), 0);
    fs_pulses(1);
    chk("collide_tick_6", 32'(frame_idx), 1);

    // Address with frame 2 and latched position (100,50).
    play_pulse();
    fs_pulses(12);
    chk("addr_frame2", 32'(frame_idx), 2);
    pos_x = 10'd100; pos_y = 10'd50;
    draw(1023, 1023);
    fs_pulses(1);
    draw(110, 60);
    @(negedge clk);
    chk("f2_addr", 32'(rom_address), 8842);
    chk("f2_act_early", 32'(sprite_active), 0);
    @(negedge clk);
    chk("f2_act", 32'(sprite_active), 1);
    draw(164, 60);
    @(negedge clk);
    chk("f2_right_addr", 32'(rom_address), 0);
    @(negedge clk);
    chk("f2_right_act", 32'(sprite_active), 0);

    // Position change mid-frame must wait for frame_start.
    pos_x = 10'd200;
    draw(110, 60);
    @(negedge clk);
    chk("pos_midframe_addr", 32'(rom_address), 8842);
    fs_pulses(1);
    chk("pos_latched_addr", 32'(rom_address), 0);
    draw(210, 60);
    @(negedge clk);
    chk("pos_moved_addr", 32'(rom_address), 8842);

    // Reset in the middle of frame 3.
    fs_pulses(4);
    chk("pre_reset_frame", 32'(frame_idx), 3);
    chk("pre_reset_addr", 32'(rom_address), 12938);
    chk("pre_reset_act", 32'(sprite_active), 1);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    chk("midreset_frame", 32'(frame_idx), 0);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_addr", 32'(rom_address), 0);
    chk("midreset_act", 32'(sprite_active), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
